pipe_ctrl: RTL

Pipeline control unit for the 5-stage Y86 core: fetch, decode, execute, memory and writeback.
- Inspects the icodes and register ids held in the D/E/M/W pipeline registers.
- Generates per-stage stall and bubble controls for load-use hazards, mispredicted jumps, ret and halt.
- A registered FSM sequences the multi-cycle ret drain and the halt shutdown.
- Maintains a saturating stall-cycle performance counter.

---
 rtl/pipe_ctrl_if.sv | 31 +++
 rtl/pipe_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_if.sv
// Hazard-control bus between the Y86 pipeline datapath and pipe_ctrl.
// The datapath (master) supplies stage icodes/registers; pipe_ctrl (slave) returns controls.
interface pipe_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       d_icode;
  logic [3:0]       d_srcA;
  logic [3:0]       d_srcB;
  logic [3:0]       e_icode;
  logic [3:0]       e_dstM;
  logic             e_cnd;
  logic             w_halt;
  logic             f_stall;
  logic             d_stall;
  logic             d_bubble;
  logic             e_bubble;
  logic             m_bubble;
  logic             w_stall;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output d_icode, d_srcA, d_srcB, e_icode, e_dstM, e_cnd, w_halt,
    input  f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall, state_o, stall_cnt
  );

  modport slave (
    input  d_icode, d_srcA, d_srcB, e_icode, e_dstM, e_cnd, w_halt,
    output f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall, state_o, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Y86 5-stage pipeline control: load-use, mispredict, ret and halt handling,
// with an FSM for the ret drain / halt shutdown and a saturating stall counter.
module pipe_ctrl #(
  parameter int CNT_W      = 16,
  parameter int RET_CYCLES = 3    // legal range 2..8
) (
  input logic          clk,
  input logic          rst,
  pipe_ctrl_if.slave   bus
);

  localparam logic [3:0] IC_HALT   = 4'h0;
  localparam logic [3:0] IC_MRMOVL = 4'h5;
  localparam logic [3:0] IC_JXX    = 4'h7;
  localparam logic [3:0] IC_RET    = 4'h9;
  localparam logic [3:0] IC_POPL   = 4'hB;
  localparam logic [3:0] REG_NONE  = 4'hF;
  localparam logic [3:0] RET_LOAD  = 4'(RET_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_RET_WAIT = 2'd1,
    S_HALTING  = 2'd2,
    S_HALTED   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_ret_cnt;
  logic [3:0]       w_ret_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_mispred;
  logic w_loaduse;
  logic w_f_stall;
  logic w_d_stall;
  logic w_d_bubble;
  logic w_e_bubble;
  logic w_m_bubble;
  logic w_w_stall;

  assign w_mispred = (bus.e_icode == IC_JXX) && !bus.e_cnd;
  assign w_loaduse = ((bus.e_icode == IC_MRMOVL) || (bus.e_icode == IC_POPL)) &&
                     (bus.e_dstM != REG_NONE) &&
                     ((bus.e_dstM == bus.d_srcA) || (bus.e_dstM == bus.d_srcB));

  always_comb begin
    w_state_nxt   = r_state;
    w_ret_cnt_nxt = r_ret_cnt;
    w_f_stall     = 1'b0;
    w_d_stall     = 1'b0;
    w_d_bubble    = 1'b0;
    w_e_bubble    = 1'b0;
    w_m_bubble    = 1'b0;
    w_w_stall     = 1'b0;
    case (r_state)
      S_RUN: begin
        // A mispredict squashes D, so a ret/halt sitting there is wrong-path.
        if (w_mispred) begin
          w_d_bubble = 1'b1;
          w_e_bubble = 1'b1;
        end else if (w_loaduse) begin
          w_f_stall  = 1'b1;
          w_d_stall  = 1'b1;
          w_e_bubble = 1'b1;
        end else if (bus.d_icode == IC_RET) begin
          w_f_stall     = 1'b1;
          w_d_bubble    = 1'b1;
          w_state_nxt   = S_RET_WAIT;
          w_ret_cnt_nxt = RET_LOAD;
        end else if (bus.d_icode == IC_HALT) begin
          w_f_stall   = 1'b1;
          w_d_bubble  = 1'b1;
          w_state_nxt = S_HALTING;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_RET_WAIT: begin
        w_f_stall     = 1'b1;
        w_d_bubble    = 1'b1;
        w_ret_cnt_nxt = r_ret_cnt - 4'd1;
        if (r_ret_cnt == 4'd1) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_RET_WAIT;
        end
      end
      S_HALTING: begin
        w_f_stall  = 1'b1;
        w_d_bubble = 1'b1;
        if (bus.w_halt) begin
          w_m_bubble  = 1'b1;
          w_w_stall   = 1'b1;
          w_state_nxt = S_HALTED;
        end else begin
          w_state_nxt = S_HALTING;
        end
      end
      S_HALTED: begin
        w_f_stall  = 1'b1;
        w_d_bubble = 1'b1;
        w_e_bubble = 1'b1;
        w_m_bubble = 1'b1;
        w_w_stall  = 1'b1;
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase
    if (w_d_stall) begin
      w_d_bubble = 1'b0;
    end else begin
      w_d_bubble = w_d_bubble;
    end
    if (rst) begin
      w_f_stall  = 1'b0;
      w_d_stall  = 1'b0;
      w_d_bubble = 1'b0;
      w_e_bubble = 1'b0;
      w_m_bubble = 1'b0;
      w_w_stall  = 1'b0;
    end else begin
      w_w_stall  = w_w_stall;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_RUN;
      r_ret_cnt <= 4'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_ret_cnt <= w_ret_cnt_nxt;
    end
  end

  // Saturating count of fetch-stall cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_f_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign bus.f_stall   = w_f_stall;
  assign bus.d_stall   = w_d_stall;
  assign bus.d_bubble  = w_d_bubble;
  assign bus.e_bubble  = w_e_bubble;
  assign bus.m_bubble  = w_m_bubble;
  assign bus.w_stall   = w_w_stall;
  assign bus.state_o   = r_state;
  assign bus.stall_cnt = r_stall_cnt;

endmodule
